alu_issue_stage: RTL and testbench

Single-entry decode-to-execute pipeline register that sits directly upstream of the ALU and drives its `srcA`, `srcB` and `alu_ctrl` inputs. Each cycle it captures one decoded instruction, resolves both register operands against the MEM and WB forwarding buses, and selects the immediate for operand B when required. It stalls on load-use hazards and supports a synchronous flush for branch redirects.

---
 rtl/alu_issue_stage.sv | 109 ++++++++++
 tb/tb_alu_issue_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decode-to-execute register with operand forwarding, load-use stall and flush
module alu_issue_stage #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RADDR-1:0] in_rs1,
   input  logic [RADDR-1:0] in_rs2,
   input  logic [XLEN-1:0]  in_rs1_data,
   input  logic [XLEN-1:0]  in_rs2_data,
   input  logic [XLEN-1:0]  in_imm,
   input  logic             in_alu_src,
   input  logic [2:0]       in_alu_ctrl,
   input  logic [RADDR-1:0] in_rd,
   input  logic             in_reg_write,
   input  logic             flush,
   input  logic             mem_fwd_en,
   input  logic [RADDR-1:0] mem_fwd_rd,
   input  logic [XLEN-1:0]  mem_fwd_data,
   input  logic             mem_fwd_is_load,
   input  logic             wb_fwd_en,
   input  logic [RADDR-1:0] wb_fwd_rd,
   input  logic [XLEN-1:0]  wb_fwd_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  srcA,
   output logic [XLEN-1:0]  srcB,
   output logic [2:0]       alu_ctrl,
   output logic [RADDR-1:0] rd,
   output logic             reg_write
);

   logic             hazard;
   logic             capture;
   logic             hold;
   logic [XLEN-1:0]  rs1_val;
   logic [XLEN-1:0]  rs2_val;
   logic [RADDR-1:0] held_rs1;
   logic [RADDR-1:0] held_rs2;
   logic             held_alu_src;
   logic             reg_write_q;

   always_comb begin
      hazard = mem_fwd_en && mem_fwd_is_load && (mem_fwd_rd != '0) &&
               ((mem_fwd_rd == in_rs1) || (!in_alu_src && (mem_fwd_rd == in_rs2)));
   end

   assign in_ready  = !hazard && (!out_valid || out_ready);
   assign capture   = in_valid && in_ready && !flush;
   assign hold      = out_valid && !out_ready;
   assign reg_write = reg_write_q && out_valid;

   // MEM beats WB; a matching MEM load never reaches here because hazard blocks capture.
   always_comb begin
      rs1_val = in_rs1_data;
      if (in_rs1 == '0)
         rs1_val = '0;
      else if (mem_fwd_en && (mem_fwd_rd == in_rs1))
         rs1_val = mem_fwd_data;
      else if (wb_fwd_en && (wb_fwd_rd == in_rs1))
         rs1_val = wb_fwd_data;

      rs2_val = in_rs2_data;
      if (in_rs2 == '0)
         rs2_val = '0;
      else if (mem_fwd_en && (mem_fwd_rd == in_rs2))
         rs2_val = mem_fwd_data;
      else if (wb_fwd_en && (wb_fwd_rd == in_rs2))
         rs2_val = wb_fwd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         srcA         <= '0;
         srcB         <= '0;
         alu_ctrl     <= 3'b000;
         rd           <= '0;
         reg_write_q  <= 1'b0;
         held_rs1     <= '0;
         held_rs2     <= '0;
         held_alu_src <= 1'b0;
      end else if (capture) begin
         out_valid    <= 1'b1;
         srcA         <= rs1_val;
         srcB         <= in_alu_src ? in_imm : rs2_val;
         alu_ctrl     <= in_alu_ctrl;
         rd           <= in_rd;
         reg_write_q  <= in_reg_write;
         held_rs1     <= in_rs1;
         held_rs2     <= in_rs2;
         held_alu_src <= in_alu_src;
      end else begin
         if (flush || out_ready)
            out_valid <= 1'b0;
         // A stalled instruction keeps picking up late WB results for its sources.
         if (hold && wb_fwd_en) begin
            if ((held_rs1 != '0) && (wb_fwd_rd == held_rs1))
               srcA <= wb_fwd_data;
            if (!held_alu_src && (held_rs2 != '0) && (wb_fwd_rd == held_rs2))
               srcB <= wb_fwd_data;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed vector bench for alu_issue_stage
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm;
   logic        in_alu_src, in_reg_write;
   logic [2:0]  in_alu_ctrl;
   logic        flush;
   logic        mem_fwd_en, mem_fwd_is_load;
   logic [4:0]  mem_fwd_rd;
   logic [31:0] mem_fwd_data;
   logic        wb_fwd_en;
   logic [4:0]  wb_fwd_rd;
   logic [31:0] wb_fwd_data;
   logic        out_valid, out_ready;
   logic [31:0] srcA, srcB;
   logic [2:0]  alu_ctrl;
   logic [4:0]  rd;
   logic        reg_write;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.XLEN(32), .RADDR(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_alu_src(in_alu_src), .in_alu_ctrl(in_alu_ctrl),
      .in_rd(in_rd), .in_reg_write(in_reg_write), .flush(flush),
      .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd),
      .mem_fwd_data(mem_fwd_data), .mem_fwd_is_load(mem_fwd_is_load),
      .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .srcA(srcA), .srcB(srcB), .alu_ctrl(alu_ctrl), .rd(rd), .reg_write(reg_write)
   );

   typedef struct {
      logic [4:0]  rs1;
      logic [31:0] rs1_d;
      logic [4:0]  rs2;
      logic [31:0] rs2_d;
      logic [31:0] imm;
      logic        alu_src;
      logic [2:0]  ctrl;
      logic [4:0]  rd;
      logic        regw;
      logic        mem_en;
      logic [4:0]  mem_rd;
      logic [31:0] mem_d;
      logic        mem_ld;
      logic        wb_en;
      logic [4:0]  wb_rd;
      logic [31:0] wb_d;
      logic        exp_ready;
      logic        exp_valid;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(
      input logic [4:0] rs1, input logic [31:0] rs1_d,
      input logic [4:0] rs2, input logic [31:0] rs2_d,
      input logic [31:0] imm, input logic alu_src, input logic [2:0] ctrl,
      input logic [4:0] rdi, input logic regw,
      input logic mem_en, input logic [4:0] mem_rd, input logic [31:0] mem_d, input logic mem_ld,
      input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_d,
      input logic exp_ready, input logic exp_valid,
      input logic [31:0] exp_a, input logic [31:0] exp_b);
      vec_t v;
      v.rs1 = rs1; v.rs1_d = rs1_d; v.rs2 = rs2; v.rs2_d = rs2_d;
      v.imm = imm; v.alu_src = alu_src; v.ctrl = ctrl; v.rd = rdi; v.regw = regw;
      v.mem_en = mem_en; v.mem_rd = mem_rd; v.mem_d = mem_d; v.mem_ld = mem_ld;
      v.wb_en = wb_en; v.wb_rd = wb_rd; v.wb_d = wb_d;
      v.exp_ready = exp_ready; v.exp_valid = exp_valid; v.exp_a = exp_a; v.exp_b = exp_b;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_data = 0; in_rs2_data = 0;
      in_imm = 0; in_alu_src = 0; in_alu_ctrl = 0; in_rd = 0; in_reg_write = 0;
      flush = 0; mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0; mem_fwd_is_load = 0;
      wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0; out_ready = 1;
   endtask

   task automatic drive(input vec_t v);
      in_valid = 1; in_rs1 = v.rs1; in_rs1_data = v.rs1_d; in_rs2 = v.rs2; in_rs2_data = v.rs2_d;
      in_imm = v.imm; in_alu_src = v.alu_src; in_alu_ctrl = v.ctrl; in_rd = v.rd;
      in_reg_write = v.regw; mem_fwd_en = v.mem_en; mem_fwd_rd = v.mem_rd;
      mem_fwd_data = v.mem_d; mem_fwd_is_load = v.mem_ld; wb_fwd_en = v.wb_en;
      wb_fwd_rd = v.wb_rd; wb_fwd_data = v.wb_d; flush = 0; out_ready = 1;
   endtask

   initial begin
      // inputs, then expected {in_ready, out_valid, srcA, srcB}
      vecs[0] = mk(1, 5,     2, 7,     0,     0, 3'b000, 10, 1, 0, 0, 0,     0, 0, 0, 0,     1, 1, 5,      7);
      vecs[1] = mk(3, 1,     0, 'h99,  0,     0, 3'b001, 11, 1, 1, 3, 'h11, 0, 1, 3, 'h22,  1, 1, 'h11,   0);
      vecs[2] = mk(3, 1,     0, 'h99,  0,     0, 3'b010, 12, 0, 0, 0, 0,     0, 1, 3, 'h22,  1, 1, 'h22,   0);
      vecs[3] = mk(0, 'h55,  1, 8,     0,     0, 3'b011, 13, 1, 1, 0, 'h11, 0, 1, 0, 'h22,  1, 1, 0,      8);
      vecs[4] = mk(1, 2,     4, 3,     0,     0, 3'b000, 14, 1, 1, 4, 'h44, 1, 0, 0, 0,     0, 0, 0,      0);
      vecs[5] = mk(1, 2,     4, 3,     0,     0, 3'b000, 15, 1, 0, 0, 0,     0, 1, 4, 9,     1, 1, 2,      9);
      vecs[6] = mk(5, 'hA,   4, 3,     'h123, 1, 3'b101, 16, 1, 1, 4, 'h44, 1, 0, 0, 0,     1, 1, 'hA,    'h123);
      vecs[7] = mk(4, 1,     2, 3,     0,     0, 3'b001, 17, 1, 1, 4, 'h44, 1, 0, 0, 0,     0, 0, 0,      0);
      vecs[8] = mk(0, 1,     2, 3,     0,     0, 3'b001, 18, 1, 1, 0, 'h44, 1, 0, 0, 0,     1, 1, 0,      3);
      vecs[9] = mk(1, 5,     2, 3,     0,     0, 3'b010, 19, 0, 1, 1, 'h66, 0, 1, 2, 'h77,  1, 1, 'h66,   'h77);

      // Reset with junk inputs applied
      set_idle();
      rst_n = 0;
      in_valid = 1; in_rs1 = 5'($urandom); in_rs1_data = $urandom; in_rs2 = 5'($urandom);
      in_rs2_data = $urandom; in_imm = $urandom; in_alu_ctrl = 3'($urandom);
      in_rd = 5'($urandom); in_reg_write = 1; in_alu_src = 1'($urandom);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_srcA", srcA, 0);
      chk("rst_srcB", srcB, 0);
      chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
      chk("rst_rd", 32'(rd), 0);
      chk("rst_reg_write", 32'(reg_write), 0);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            chk($sformatf("v%0d_srcA", i), srcA, vecs[i].exp_a);
            chk($sformatf("v%0d_srcB", i), srcB, vecs[i].exp_b);
            chk($sformatf("v%0d_alu_ctrl", i), 32'(alu_ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_reg_write", i), 32'(reg_write), 32'(vecs[i].regw));
         end else begin
            chk($sformatf("v%0d_reg_write_masked", i), 32'(reg_write), 0);
         end
      end

      // Backpressure refresh: WB updates held srcA; srcB is an immediate and stays
      @(negedge clk);
      set_idle();
      in_valid = 1; in_rs1 = 6; in_rs1_data = 1; in_rs2 = 6; in_rs2_data = 2;
      in_alu_src = 1; in_imm = 5; in_rd = 7; in_reg_write = 1;
      @(posedge clk); #1;
      chk("bp_cap_srcA", srcA, 1);
      chk("bp_cap_srcB", srcB, 5);
      @(negedge clk);
      out_ready = 0; in_rs1 = 9; in_rs1_data = 'h3;
      wb_fwd_en = 1; wb_fwd_rd = 6; wb_fwd_data = 'h40;
      mem_fwd_en = 1; mem_fwd_rd = 6; mem_fwd_data = 'h99;
      #1;
      chk("bp_in_ready_0", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_srcA_refresh", srcA, 'h40);
      chk("bp_srcB_kept", srcB, 5);
      @(negedge clk);
      wb_fwd_en = 0; mem_fwd_en = 0;
      #1;
      chk("bp_in_ready_1", 32'(in_ready), 0);
      chk("bp_rd_held", 32'(rd), 7);

      // Flush while stalled, with an incoming instruction
      flush = 1; in_valid = 1; in_rs1 = 2; in_rs1_data = 'hBEEF; in_rd = 3;
      @(posedge clk); #1;
      chk("fl_out_valid", 32'(out_valid), 0);
      chk("fl_reg_write", 32'(reg_write), 0);
      @(negedge clk);
      flush = 0; in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      chk("fl_dropped", 32'(out_valid), 0);

      // Streaming: 8 back-to-back with no bubbles
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         set_idle();
         in_valid = 1; in_rs1 = 1; in_rs1_data = 32'(100 + i); in_rd = 5'(i + 1);
         in_reg_write = 1; in_alu_ctrl = 3'(i);
         #1;
         chk($sformatf("st%0d_in_ready", i), 32'(in_ready), 1);
         @(posedge clk); #1;
         chk($sformatf("st%0d_out_valid", i), 32'(out_valid), 1);
         chk($sformatf("st%0d_srcA", i), srcA, 32'(100 + i));
         chk($sformatf("st%0d_rd", i), 32'(rd), 32'(i + 1));
      end
      @(negedge clk);
      in_valid = 0;
      @(posedge clk); #1;
      chk("consume_out_valid", 32'(out_valid), 0);
      chk("consume_srcA_held", srcA, 107);
      chk("consume_reg_write", 32'(reg_write), 0);

      // Asynchronous reset in the middle of a held transfer
      @(negedge clk);
      in_valid = 1; in_rs1 = 1; in_rs1_data = 'h1234; in_rd = 9; out_ready = 0;
      @(posedge clk); #1;
      chk("ar_pre_valid", 32'(out_valid), 1);
      #1;
      rst_n = 0;
      #1;
      chk("ar_out_valid", 32'(out_valid), 0);
      chk("ar_srcA", srcA, 0);
      chk("ar_rd", 32'(rd), 0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      chk("ar_first_capture", srcA, 'h1234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
